// File: rtl/regfile_fwd.sv
// ID-stage register file with byte-enabled WB write, EX/MEM/WB operand forwarding,
// load-use hazard detection and a saturating stall-cycle counter.
module regfile_fwd #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 5,
  parameter  int NREAD  = 2,
  localparam int FWD_W  = 1 + ADDR_W + DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD-1:0]        re,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  input  logic [FWD_W-1:0]        ex_to_rf_bus,
  input  logic                    ex_is_load,
  input  logic [FWD_W-1:0]        mem_to_rf_bus,
  input  logic [DATA_W/8-1:0]     wb_we,
  input  logic [ADDR_W-1:0]       wb_waddr,
  input  logic [DATA_W-1:0]       wb_wdata,
  output logic                    stall_req,
  output logic [31:0]             stall_cnt
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int NBYTE = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [NREG];
  logic [31:0]       r_stall_cnt;

  logic              w_ex_we;
  logic [ADDR_W-1:0] w_ex_waddr;
  logic [DATA_W-1:0] w_ex_wdata;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_wb_any;
  logic [NREAD-1:0]  w_ex_hit;

  assign w_ex_we     = ex_to_rf_bus[FWD_W-1];
  assign w_ex_waddr  = ex_to_rf_bus[DATA_W +: ADDR_W];
  assign w_ex_wdata  = ex_to_rf_bus[DATA_W-1:0];
  assign w_mem_we    = mem_to_rf_bus[FWD_W-1];
  assign w_mem_waddr = mem_to_rf_bus[DATA_W +: ADDR_W];
  assign w_mem_wdata = mem_to_rf_bus[DATA_W-1:0];
  assign w_wb_any    = |wb_we;

  // Whole array is cleared on reset, so storage lives in flops rather than RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wb_waddr != '0) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (wb_we[b]) begin
          r_mem[wb_waddr][b*8 +: 8] <= wb_wdata[b*8 +: 8];
        end
      end
    end
  end

  genvar gi, gb;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_port
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_wb_merge;
      logic [DATA_W-1:0] w_data;

      assign w_addr = raddr[gi*ADDR_W +: ADDR_W];

      for (gb = 0; gb < NBYTE; gb++) begin : g_byte
        assign w_wb_merge[gb*8 +: 8] = wb_we[gb] ? wb_wdata[gb*8 +: 8]
                                                 : r_mem[w_addr][gb*8 +: 8];
      end

      always_comb begin
        w_data = r_mem[w_addr];
        if (rst || (w_addr == '0)) begin
          w_data = '0;
        end else if (w_ex_we && (w_ex_waddr == w_addr)) begin
          w_data = w_ex_wdata;
        end else if (w_mem_we && (w_mem_waddr == w_addr)) begin
          w_data = w_mem_wdata;
        end else if (w_wb_any && (wb_waddr == w_addr)) begin
          w_data = w_wb_merge;
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = w_data;
      assign w_ex_hit[gi]               = re[gi] && (w_addr == w_ex_waddr);
    end
  endgenerate

  // A load in EX has no data yet; any enabled reader of its destination must wait.
  assign stall_req = !rst && ex_is_load && w_ex_we && (w_ex_waddr != '0) && (|w_ex_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_req && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_regfile_fwd.sv
// Self-checking bench for regfile_fwd: directed scenarios plus randomized traffic
// checked against an array-based reference model of the read/forward/stall rules.
module tb_regfile_fwd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: DATA_W=32, ADDR_W=5, NREAD=2
  logic        rst;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [37:0] ex_bus;
  logic        ex_is_load;
  logic [37:0] mem_bus;
  logic [3:0]  wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        stall_req;
  logic [31:0] stall_cnt;

  // Wide instance: NREAD=4, ADDR_W=4
  logic [3:0]   re4;
  logic [15:0]  raddr4;
  logic [127:0] rdata4;
  logic [36:0]  ex4;
  logic         ex_load4;
  logic [36:0]  mem4;
  logic [3:0]   wb_we4;
  logic [3:0]   wb_waddr4;
  logic [31:0]  wb_wdata4;
  logic         stall4;
  logic [31:0]  cnt4;

  regfile_fwd dut (
    .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata),
    .ex_to_rf_bus(ex_bus), .ex_is_load(ex_is_load), .mem_to_rf_bus(mem_bus),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .stall_req(stall_req), .stall_cnt(stall_cnt)
  );

  regfile_fwd #(.DATA_W(32), .ADDR_W(4), .NREAD(4)) dut4 (
    .clk(clk), .rst(rst), .re(re4), .raddr(raddr4), .rdata(rdata4),
    .ex_to_rf_bus(ex4), .ex_is_load(ex_load4), .mem_to_rf_bus(mem4),
    .wb_we(wb_we4), .wb_waddr(wb_waddr4), .wb_wdata(wb_wdata4),
    .stall_req(stall4), .stall_cnt(cnt4)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_mem [32];
  logic [31:0] m_cnt;

  // Reference read: priority reset/r0 > EX > MEM > WB (byte merge) > stored value
  function automatic logic [31:0] ref_rd(input int p);
    logic [4:0]  a;
    logic [31:0] v;
    a = raddr[p*5 +: 5];
    if (rst || a == 5'd0) return 32'd0;
    if (ex_bus[37] && ex_bus[36:32] == a) return ex_bus[31:0];
    if (mem_bus[37] && mem_bus[36:32] == a) return mem_bus[31:0];
    v = m_mem[a];
    if (wb_we != 4'd0 && wb_waddr == a)
      for (int b = 0; b < 4; b++) if (wb_we[b]) v[b*8 +: 8] = wb_wdata[b*8 +: 8];
    return v;
  endfunction

  function automatic logic ref_stall();
    logic s;
    s = 1'b0;
    if (!rst && ex_is_load && ex_bus[37] && ex_bus[36:32] != 5'd0)
      for (int i = 0; i < 2; i++)
        if (re[i] && raddr[i*5 +: 5] == ex_bus[36:32]) s = 1'b1;
    return s;
  endfunction

  // Advance the model across one rising edge, then land on the next falling edge
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      m_cnt = 32'd0;
    end else begin
      if (ref_stall() && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (wb_waddr != 5'd0)
        for (int b = 0; b < 4; b++) if (wb_we[b]) m_mem[wb_waddr][b*8 +: 8] = wb_wdata[b*8 +: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle();
    re = '0; raddr = '0; ex_bus = '0; ex_is_load = 1'b0; mem_bus = '0;
    wb_we = '0; wb_waddr = '0; wb_wdata = '0;
    re4 = '0; raddr4 = '0; ex4 = '0; ex_load4 = 1'b0; mem4 = '0;
    wb_we4 = '0; wb_waddr4 = '0; wb_wdata4 = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    idle();
    wb_we = 4'hF; wb_waddr = a; wb_wdata = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    ex_bus = {1'b1, 5'd3, 32'hDEAD_BEEF}; ex_is_load = 1'b1; re = 2'b11; raddr = {5'd3, 5'd3};
    ex4 = {1'b1, 4'd3, 32'hDEAD_BEEF}; ex_load4 = 1'b1; re4 = 4'hF; raddr4 = 16'h3333;
    #1;
    n_cmp++; if (rdata !== 64'd0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
    n_cmp++; if (rdata4 !== 128'd0) begin n_bad++; $display("FAIL reset_rdata4: got %h expected 0", rdata4); end
    n_cmp++; if (stall4 !== 1'b0) begin n_bad++; $display("FAIL reset_stall4: got %b expected 0", stall4); end
    tick();
    rst = 1'b0;
    idle();
    #1;
    n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %h expected 0", stall_cnt); end
    for (int a = 0; a < 32; a++) begin
      raddr = {5'd0, 5'(a)};
      #1;
      n_cmp++; if (rdata[31:0] !== 32'd0) begin n_bad++; $display("FAIL reset_reg%0d: got %h expected 0", a, rdata[31:0]); end
    end
    $display("test_reset: reset values checked");
  endtask

  task automatic test_basic_write();
    wb_write(5'd5, 32'h1234_5678);
    raddr = {5'd0, 5'd5};
    #1;
    n_cmp++; if (rdata[31:0] !== 32'h1234_5678) begin n_bad++; $display("FAIL basic_r5: got %h expected 12345678", rdata[31:0]); end
    n_cmp++; if (rdata[63:32] !== 32'd0) begin n_bad++; $display("FAIL basic_r0: got %h expected 0", rdata[63:32]); end
    wb_write(5'd0, 32'hFFFF_FFFF);
    raddr = {5'd5, 5'd0};
    #1;
    n_cmp++; if (rdata[31:0] !== 32'd0) begin n_bad++; $display("FAIL basic_r0_after_write: got %h expected 0", rdata[31:0]); end
    n_cmp++; if (rdata[63:32] !== 32'h1234_5678) begin n_bad++; $display("FAIL basic_r5_port1: got %h expected 12345678", rdata[63:32]); end
    $display("test_basic_write: r5 write, r0 immunity");
    idle();
  endtask

  task automatic test_priority();
    logic [31:0] e4 [4];
    wb_write(5'd5, 32'h1234_5678);
    raddr = {5'd5, 5'd5};
    ex_bus = {1'b1, 5'd5, 32'hAAAA_AAAA};
    mem_bus = {1'b1, 5'd5, 32'hBBBB_BBBB};
    wb_we = 4'hF; wb_waddr = 5'd5; wb_wdata = 32'hCCCC_CCCC;
    #1;
    n_cmp++; if (rdata !== {2{32'hAAAA_AAAA}}) begin n_bad++; $display("FAIL prio_ex: got %h expected AAAAAAAA x2", rdata); end
    ex_bus[37] = 1'b0;
    #1;
    n_cmp++; if (rdata !== {2{32'hBBBB_BBBB}}) begin n_bad++; $display("FAIL prio_mem: got %h expected BBBBBBBB x2", rdata); end
    mem_bus[37] = 1'b0;
    #1;
    n_cmp++; if (rdata !== {2{32'hCCCC_CCCC}}) begin n_bad++; $display("FAIL prio_wb: got %h expected CCCCCCCC x2", rdata); end
    tick();
    idle();
    raddr = {5'd5, 5'd5};
    #1;
    n_cmp++; if (rdata !== {2{32'hCCCC_CCCC}}) begin n_bad++; $display("FAIL prio_committed: got %h expected CCCCCCCC x2", rdata); end

    // Same sequence on the four-port, 16-register instance
    idle();
    wb_we4 = 4'hF; wb_waddr4 = 4'd5; wb_wdata4 = 32'h1234_5678;
    tick();
    raddr4 = {4'd0, 4'd3, 4'd5, 4'd5};
    ex4 = {1'b1, 4'd5, 32'hAAAA_AAAA};
    mem4 = {1'b1, 4'd5, 32'hBBBB_BBBB};
    wb_we4 = 4'hF; wb_waddr4 = 4'd5; wb_wdata4 = 32'hCCCC_CCCC;
    for (int step = 0; step < 3; step++) begin
      if (step == 1) ex4[36] = 1'b0;
      if (step == 2) mem4[36] = 1'b0;
      #1;
      e4[0] = (step == 0) ? 32'hAAAA_AAAA : (step == 1) ? 32'hBBBB_BBBB : 32'hCCCC_CCCC;
      e4[1] = e4[0];
      e4[2] = 32'd0;
      e4[3] = 32'd0;
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (rdata4[p*32 +: 32] !== e4[p]) begin
          n_bad++; $display("FAIL prio4_step%0d_port%0d: got %h expected %h", step, p, rdata4[p*32 +: 32], e4[p]);
        end
      end
    end
    tick();
    idle();
    $display("test_priority: EX > MEM > WB on 2-port and 4-port instances");
  endtask

  task automatic test_partial_wb();
    wb_write(5'd5, 32'h1234_5678);
    wb_we = 4'b0011; wb_waddr = 5'd5; wb_wdata = 32'hFFFF_9ABC;
    raddr = {5'd0, 5'd5};
    #1;
    n_cmp++; if (rdata[31:0] !== 32'h1234_9ABC) begin n_bad++; $display("FAIL partial_fwd: got %h expected 12349ABC", rdata[31:0]); end
    tick();
    idle();
    raddr = {5'd0, 5'd5};
    #1;
    n_cmp++; if (rdata[31:0] !== 32'h1234_9ABC) begin n_bad++; $display("FAIL partial_array: got %h expected 12349ABC", rdata[31:0]); end
    $display("test_partial_wb: byte-enabled forward and commit");
    idle();
  endtask

  task automatic test_load_use();
    idle();
    ex_bus = {1'b1, 5'd7, 32'h5566_7788}; ex_is_load = 1'b1; raddr = {5'd0, 5'd7}; re = 2'b01;
    #1;
    n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b expected 1", stall_req); end
    re = 2'b00;
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL lu_re_off: got %b expected 0", stall_req); end
    re = 2'b01; ex_bus[36:32] = 5'd0; raddr = {5'd0, 5'd0};
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL lu_r0: got %b expected 0", stall_req); end
    ex_bus[36:32] = 5'd7; raddr = {5'd0, 5'd7}; ex_is_load = 1'b0;
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL lu_not_load: got %b expected 0", stall_req); end
    n_cmp++; if (rdata[31:0] !== 32'h5566_7788) begin n_bad++; $display("FAIL lu_fwd: got %h expected 55667788", rdata[31:0]); end
    ex_is_load = 1'b1; re = 2'b10; raddr = {5'd7, 5'd3};
    #1;
    n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL lu_port1: got %b expected 1", stall_req); end
    idle();
    tick();
    $display("test_load_use: hazard qualifiers");
  endtask

  task automatic test_counter();
    idle();
    apply_reset();
    ex_bus = {1'b1, 5'd7, 32'h0}; ex_is_load = 1'b1; raddr = {5'd0, 5'd7}; re = 2'b01;
    repeat (5) tick();
    #1;
    n_cmp++; if (stall_cnt !== 32'd5) begin n_bad++; $display("FAIL cnt_five: got %0d expected 5", stall_cnt); end
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    m_cnt = 32'hFFFF_FFFE;
    for (int k = 1; k <= 3; k++) begin
      tick();
      #1;
      n_cmp++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cnt_sat_%0d: got %h expected FFFFFFFF", k, stall_cnt); end
    end
    idle();
    apply_reset();
    $display("test_counter: count and saturation");
  endtask

  task automatic test_random();
    logic [31:0] e0, e1;
    logic        es;
    for (int t = 0; t < 400; t++) begin
      rst        = ($urandom_range(0, 59) == 0);
      re         = 2'($urandom);
      raddr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_bus     = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom)};
      ex_is_load = ($urandom_range(0, 2) == 0);
      mem_bus    = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom)};
      wb_we      = 4'($urandom);
      wb_waddr   = 5'($urandom_range(0, 7));
      wb_wdata   = 32'($urandom);
      #1;
      e0 = ref_rd(0);
      e1 = ref_rd(1);
      es = ref_stall();
      $display("txn %0d rst=%b raddr=%h rdata=%h stall=%b cnt=%0d", t, rst, raddr, rdata, stall_req, stall_cnt);
      n_cmp++; if (rdata[31:0] !== e0) begin n_bad++; $display("FAIL rnd%0d_port0: got %h expected %h", t, rdata[31:0], e0); end
      n_cmp++; if (rdata[63:32] !== e1) begin n_bad++; $display("FAIL rnd%0d_port1: got %h expected %h", t, rdata[63:32], e1); end
      n_cmp++; if (stall_req !== es) begin n_bad++; $display("FAIL rnd%0d_stall: got %b expected %b", t, stall_req, es); end
      n_cmp++; if (stall_cnt !== m_cnt) begin n_bad++; $display("FAIL rnd%0d_cnt: got %0d expected %0d", t, stall_cnt, m_cnt); end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_reset_mid_stall();
    wb_write(5'd9, 32'h0000_0001);
    ex_bus = {1'b1, 5'd9, 32'hFACE_0000}; ex_is_load = 1'b1; raddr = {5'd0, 5'd9}; re = 2'b01;
    tick();
    #1;
    n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL mid_pre_stall: got %b expected 1", stall_req); end
    rst = 1'b1;
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL mid_stall_drop: got %b expected 0", stall_req); end
    n_cmp++; if (rdata[31:0] !== 32'd0) begin n_bad++; $display("FAIL mid_rdata: got %h expected 0", rdata[31:0]); end
    tick();
    rst = 1'b0;
    idle();
    #1;
    n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_cnt: got %0d expected 0", stall_cnt); end
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'd0};
      #1;
      n_cmp++; if (rdata[63:32] !== 32'd0) begin n_bad++; $display("FAIL mid_reg%0d: got %h expected 0", a, rdata[63:32]); end
    end
    $display("test_reset_mid_stall: stall dropped, state cleared");
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_basic_write();
    test_priority();
    test_partial_wb();
    test_load_use();
    test_counter();
    test_random();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_fwd.md
# regfile_fwd

Parametrised general-purpose register file for the ID stage of the five-stage pipeline. It provides NREAD combinational read ports, one byte-enabled write port driven by WB, and full operand forwarding from the EX and MEM stage buses. It also detects load-use hazards against the EX stage, raises a stall request, and counts stall cycles in a saturating counter.

## Interface
- DATA_W, 32, register width in bits; multiple of 8.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- NREAD, 2, number of read ports (1..4).
- FWD_W, 1+ADDR_W+DATA_W, width of each forwarding bus (derived, not overridden).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- re  in  NREAD  per-port read-enable; qualifies hazard detection only.
- raddr  in  NREAD*ADDR_W  port i address at bits [i*ADDR_W +: ADDR_W].
- rdata  out  NREAD*DATA_W  port i data at bits [i*DATA_W +: DATA_W].
- ex_to_rf_bus  in  FWD_W  {we, waddr, wdata} from EX; we is the MSB.
- ex_is_load  in  1  EX instruction is a load; its wdata is not yet valid.
- mem_to_rf_bus  in  FWD_W  {we, waddr, wdata} from MEM, with final load data.
- wb_we  in  DATA_W/8  WB byte write enables.
- wb_waddr  in  ADDR_W  WB destination.
- wb_wdata  in  DATA_W  WB data.
- stall_req  out  1  load-use hazard; ID must hold.
- stall_cnt  out  32  saturating count of cycles with stall_req=1.

## Operation
- Storage: NREG x DATA_W array. Register 0 reads 0 and is never written.
- Write: at posedge, if !rst and wb_waddr!=0, byte b of reg[wb_waddr] takes wb_wdata byte b for each set wb_we[b]. Other bytes are unchanged.
- Per-port read resolution, evaluated in priority order; the first match wins:
  1. rst=1 -> 0.
  2. raddr=0 -> 0.
  3. EX we=1 and EX waddr=raddr -> EX wdata.
  4. MEM we=1 and MEM waddr=raddr -> MEM wdata.
  5. |wb_we and wb_waddr=raddr -> per byte: wb_wdata where wb_we set, otherwise the array byte.
  6. Otherwise -> array[raddr].
- Forwarding does not depend on re. An unused port may return any legal resolved value.
- Hazard: stall_req = !rst & ex_is_load & EX we & (EX waddr!=0) & OR over i of (re[i] & raddr_i==EX waddr).
  - When stall_req=1, the affected port still returns EX wdata. This value is don't-care to the consumer.
- stall_cnt: cleared by rst. Increments by 1 at each posedge where stall_req=1. Saturates at 0xFFFF_FFFF.

## Timing
- Reads, forwarding and stall_req are purely combinational from inputs and the array. Zero-cycle latency.
- A write at edge N is visible from the array after edge N. In the cycle of the write it is visible through forwarding rule 5.
- Simultaneous matches: EX beats MEM, and MEM beats WB, even if a lower-priority source has only a partial-byte write.
- Reset:
  - While rst=1: rdata=0, stall_req=0, and writes are blocked.
  - At the first posedge with rst=1, every array entry is cleared to 0 and stall_cnt is cleared to 0.
- Reset asserted mid-stall: stall_req drops the same cycle and the count is cleared at that edge.
- Reset deasserted: normal operation resumes the next cycle. The array holds all zeros.

## Test plan
- Reset, then WB full write to r5 = 0x1234_5678. Next cycle, read r5 with no forwarding -> 0x1234_5678. Read r0 -> 0. A write to r0 leaves r0 = 0.
- Priority and width: r5 = 0x1234_5678 in the array. Drive EX {1,5,0xAAAA_AAAA}, MEM {1,5,0xBBBB_BBBB} and WB r5 = 0xCCCC_CCCC in the same cycle -> rdata = 0xAAAA_AAAA. Drop EX -> 0xBBBB_BBBB. Drop MEM -> 0xCCCC_CCCC. Repeat with NREAD=4 and ADDR_W=4, checking every port independently.
- Partial WB forward: r5 = 0x1234_5678, wb_we = 4'b0011, wb_wdata = 0xFFFF_9ABC, read r5 -> 0x1234_9ABC. Next cycle with no writes -> 0x1234_9ABC.
- Load-use:
  - EX {1,7,x} with ex_is_load=1, raddr0 = 7 and re[0]=1 -> stall_req=1.
  - Set re[0]=0 -> stall_req=0.
  - EX waddr=0 -> stall_req=0.
  - ex_is_load=0 -> stall_req=0 and rdata = EX wdata.
- Counter: hold the stall condition for 5 cycles -> stall_cnt = 5. Preload near saturation (force 0xFFFF_FFFE), stall 3 cycles -> 0xFFFF_FFFF.
- Reset mid-stall: assert rst during an active stall -> stall_req=0 and rdata=0 the same cycle. After the edge, stall_cnt=0 and all registers read 0.
